mdr_mem_port: RTL

//   Memory-side datapath stage for the single-bus CPU: consumes the bus mux output (BusMuxOut) into MAR/MDR
//   and produces the MDR value that the bus mux drives onto the bus when MDR is selected.

---
 rtl/mdr_mem_port_if.sv | 31 +++
 rtl/mdr_mem_port.sv | 80 ++++++++
 2 files changed

// File: rtl/mdr_mem_port_if.sv
// mdr_mem_port_if: bus-mux, control-strobe and memory handshake signals of the MDR/MAR port.
interface mdr_mem_port_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic [DATA_W-1:0] bus_in;
    logic              mar_in;
    logic              mdr_in;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] mdr_out;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_req;
    logic              mem_we;
    logic              mem_ack;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  bus_in, mar_in, mdr_in, read, write, mem_rdata, mem_ack,
        output mdr_out, mem_addr, mem_wdata, mem_req, mem_we, busy, done, err
    );

    modport master (
        output bus_in, mar_in, mdr_in, read, write, mem_rdata, mem_ack,
        input  mdr_out, mem_addr, mem_wdata, mem_req, mem_we, busy, done, err
    );
endinterface

// File: rtl/mdr_mem_port.sv
// mdr_mem_port: MAR/MDR registers and req/ack memory transactions with timeout.
module mdr_mem_port #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           reset_n,
    mdr_mem_port_if.slave  bus
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d, addr_q, addr_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              req_q, req_d, we_q, we_d, done_q, done_d, err_q, err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mar_q   <= '0;
            addr_q  <= '0;
            mdr_q   <= '0;
            timer_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            addr_q  <= addr_d;
            mdr_q   <= mdr_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        timer_d = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (state_q == IDLE) begin
            state_d = bus.write ? WR : (bus.mdr_in && bus.read) ? RD : IDLE;
            mdr_d   = (!bus.write && bus.mdr_in && !bus.read) ? bus.bus_in : mdr_q;
            mar_d   = bus.mar_in ? bus.bus_in[ADDR_W-1:0] : mar_q;
        end else if (bus.mem_ack) begin
            state_d = IDLE;
            done_d  = 1'b1;
            mdr_d   = (state_q == RD) ? bus.mem_rdata : mdr_q;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else begin
            timer_d = timer_q + TW'(1);
        end
        // a transaction keeps the address MAR held before its start edge
        addr_d = (state_d == IDLE) ? mar_d : (state_q == IDLE) ? mar_q : addr_q;
        req_d  = state_d != IDLE;
        we_d   = state_d == WR;
    end

    assign bus.mdr_out   = mdr_q;
    assign bus.mem_wdata = mdr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.busy      = req_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
